// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU: memory-responder FSM encoding,
// word size, and the ALU / execution-unit constants used by the control path.
package cpu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } mem_state_e;

  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_cmd_e;

  localparam logic [3:0] EX_ALU    = 4'b0001;
  localparam logic [3:0] EX_MEM    = 4'b0010;
  localparam logic [3:0] EX_BRANCH = 4'b0100;
  localparam logic [3:0] EX_JUMP   = 4'b1000;

  function automatic logic word_aligned(input logic [31:0] byte_off);
    return (byte_off[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/data_ram_resp.sv
// Data-memory responder: one word access per rising mem_rd/mem_wr strobe,
// registered read data, and ack/err pulses with saturating statistics.
module data_ram_resp
  import cpu_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_rd,
  input  logic             mem_wr,
  input  logic [31:0]      addr,
  input  logic [31:0]      wr_data,
  output logic [31:0]      rd_data,
  output logic             ack,
  output logic             err,
  output logic             busy,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0] mem_q [DEPTH_WORDS];

  mem_state_e       state_d, state_q;
  logic             prev_rd_d, prev_rd_q;
  logic             prev_wr_d, prev_wr_q;
  logic [31:0]      rd_data_d, rd_data_q;
  logic             ack_d, ack_q;
  logic             err_d, err_q;

  logic [31:0]      off_s;
  logic             addr_ok_s;
  logic [IDX_W-1:0] idx_s;
  logic             rd_rise_s;
  logic             wr_rise_s;
  logic             mem_we_s;
  logic             rd_inc_s;
  logic             wr_inc_s;
  logic             err_inc_s;

  assign off_s     = addr - BASE_ADDR;
  assign addr_ok_s = word_aligned(off_s) && ({2'b00, off_s[31:2]} < 32'(DEPTH_WORDS));
  assign idx_s     = off_s[IDX_W+1:2];
  assign rd_rise_s = mem_rd & ~prev_rd_q;
  assign wr_rise_s = mem_wr & ~prev_wr_q;

  always_comb begin
    state_d   = state_q;
    prev_rd_d = mem_rd;
    prev_wr_d = mem_wr;
    rd_data_d = rd_data_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    mem_we_s  = 1'b0;
    rd_inc_s  = 1'b0;
    wr_inc_s  = 1'b0;
    err_inc_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_rise_s || wr_rise_s) begin
          state_d = HOLD;
          // Both strobes rising together is ambiguous, so it takes the error path.
          if (rd_rise_s && !wr_rise_s && addr_ok_s) begin
            rd_data_d = mem_q[idx_s];
            ack_d     = 1'b1;
            rd_inc_s  = 1'b1;
          end else if (wr_rise_s && !rd_rise_s && addr_ok_s) begin
            mem_we_s  = 1'b1;
            ack_d     = 1'b1;
            wr_inc_s  = 1'b1;
          end else begin
            rd_data_d = 32'h0000_0000;
            err_d     = 1'b1;
            err_inc_s = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (!mem_rd && !mem_wr) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      prev_rd_q <= 1'b0;
      prev_wr_q <= 1'b0;
      rd_data_q <= 32'h0000_0000;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_rd_q <= prev_rd_d;
      prev_wr_q <= prev_wr_d;
      rd_data_q <= rd_data_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end

  // Array is deliberately not reset; a write landing on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (mem_we_s && !rst) begin
      mem_q[idx_s] <= wr_data;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_rd_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (rd_inc_s),
    .count (rd_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_wr_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (wr_inc_s),
    .count (wr_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc_s),
    .count (err_count)
  );

  assign rd_data = rd_data_q;
  assign ack     = ack_q;
  assign err     = err_q;
  assign busy    = (state_q == HOLD);

endmodule

// File: tb/tb_data_ram_resp.sv
// Self-checking bench for data_ram_resp: directed scenarios followed by
// randomized accesses, all checked against a word-level behavioural model.
module tb_data_ram_resp;

  localparam int          DEPTH = 64;
  localparam int          CW    = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_rd = 1'b0;
  logic          mem_wr = 1'b0;
  logic [31:0]   addr = 32'h0;
  logic [31:0]   wr_data = 32'h0;
  logic [31:0]   rd_data;
  logic          ack;
  logic          err;
  logic          busy;
  logic [CW-1:0] rd_count;
  logic [CW-1:0] wr_count;
  logic [CW-1:0] err_count;

  int n_cmp = 0;
  int n_mis = 0;

  logic [31:0] mdl_mem [DEPTH];
  logic [31:0] e_rd_data = 32'h0;
  int          e_rdc = 0;
  int          e_wrc = 0;
  int          e_errc = 0;
  logic        e_ack = 1'b0;
  logic        e_err = 1'b0;

  data_ram_resp #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE),
    .CNT_W       (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .addr      (addr),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .ack       (ack),
    .err       (err),
    .busy      (busy),
    .rd_count  (rd_count),
    .wr_count  (wr_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int c);
    return (c >= CMAX) ? c : c + 1;
  endfunction

  task automatic check_outputs(input logic xa, input logic xe, input logic xb, input string tag);
    chk({tag, ".ack"},  {31'd0, ack},  {31'd0, xa});
    chk({tag, ".err"},  {31'd0, err},  {31'd0, xe});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, xb});
    chk({tag, ".rd_data"}, rd_data, e_rd_data);
    chk({tag, ".rd_count"},  {{(32-CW){1'b0}}, rd_count},  32'(e_rdc));
    chk({tag, ".wr_count"},  {{(32-CW){1'b0}}, wr_count},  32'(e_wrc));
    chk({tag, ".err_count"}, {{(32-CW){1'b0}}, err_count}, 32'(e_errc));
  endtask

  task automatic step(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic xa, input logic xe, input logic xb, input string tag);
    @(negedge clk);
    mem_rd  = rd;
    mem_wr  = wr;
    addr    = a;
    wr_data = d;
    @(posedge clk);
    #1;
    check_outputs(xa, xe, xb, tag);
  endtask

  // Word-level view of one accepted access: what the outside world should see.
  task automatic model_access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] off;
    bit ok;
    off = a - BASE;
    ok  = (off % 4 == 0) && ((off / 4) < DEPTH);
    if ((rd && wr) || !ok) begin
      e_ack = 1'b0;
      e_err = 1'b1;
      e_rd_data = 32'h0;
      e_errc = sat_inc(e_errc);
    end else if (rd) begin
      e_ack = 1'b1;
      e_err = 1'b0;
      e_rd_data = mdl_mem[off / 4];
      e_rdc = sat_inc(e_rdc);
    end else begin
      e_ack = 1'b1;
      e_err = 1'b0;
      mdl_mem[off / 4] = d;
      e_wrc = sat_inc(e_wrc);
    end
  endtask

  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input int hold, input string tag);
    model_access(rd, wr, a, d);
    step(rd, wr, a, d, e_ack, e_err, 1'b1, {tag, ".first"});
    for (int i = 1; i < hold; i++) begin
      step(rd, wr, a, d, 1'b0, 1'b0, 1'b1, {tag, ".hold"});
    end
    step(1'b0, 1'b0, a, d, 1'b0, 1'b0, 1'b0, {tag, ".drop"});
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rd_v;
    int kind;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs(1'b0, 1'b0, 1'b0, "reset");
    @(negedge clk);
    rst = 1'b0;

    // Basic write then read of word 2
    access(1'b0, 1'b1, 32'h8, 32'hDEADBEEF, 3, "wr8");
    access(1'b1, 1'b0, 32'h8, 32'h0, 2, "rd8");

    // Bottom and top words, then one past the end
    access(1'b0, 1'b1, 32'h0, 32'h1, 1, "wr_lo");
    access(1'b0, 1'b1, 32'(4 * (DEPTH - 1)), 32'h2, 2, "wr_hi");
    access(1'b1, 1'b0, 32'h0, 32'h0, 1, "rd_lo");
    access(1'b1, 1'b0, 32'(4 * (DEPTH - 1)), 32'h0, 1, "rd_hi");
    access(1'b1, 1'b0, 32'(4 * DEPTH), 32'h0, 2, "rd_oor");

    // Misaligned write must leave word 1 alone
    access(1'b0, 1'b1, 32'h4, 32'hCAFE_0001, 1, "wr4");
    access(1'b0, 1'b1, 32'h6, 32'hBAD0_BAD0, 2, "wr_mis");
    access(1'b1, 1'b0, 32'h4, 32'h0, 1, "rd4");

    // Simultaneous rise is rejected and writes nothing
    access(1'b0, 1'b1, 32'h20, 32'h0000_0011, 1, "wr20");
    access(1'b1, 1'b1, 32'h20, 32'h0000_0077, 2, "both");
    access(1'b1, 1'b0, 32'h20, 32'h0, 1, "rd20");

    // Read strobe rising while the write strobe is still held is ignored
    model_access(1'b0, 1'b1, 32'h10, 32'h0000_0055);
    step(1'b0, 1'b1, 32'h10, 32'h0000_0055, e_ack, e_err, 1'b1, "hrise.wr");
    step(1'b1, 1'b1, 32'h10, 32'h0000_0055, 1'b0, 1'b0, 1'b1, "hrise.rd");
    step(1'b1, 1'b1, 32'h10, 32'h0000_0055, 1'b0, 1'b0, 1'b1, "hrise.hold");
    step(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, "hrise.drop");
    access(1'b1, 1'b0, 32'h10, 32'h0, 1, "rd10");

    // Reset during the hold of a read
    model_access(1'b1, 1'b0, 32'h8, 32'h0);
    step(1'b1, 1'b0, 32'h8, 32'h0, e_ack, e_err, 1'b1, "rstmid.rd");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    e_rd_data = 32'h0;
    e_rdc = 0;
    e_wrc = 0;
    e_errc = 0;
    check_outputs(1'b0, 1'b0, 1'b0, "rstmid.rst");
    step(1'b0, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0, 1'b0, "rstmid.rel");
    @(negedge clk);
    rst = 1'b0;
    access(1'b1, 1'b0, 32'h8, 32'h0, 2, "rstmid.fresh");

    // Read counter saturation
    for (int i = 0; i < (1 << CW) + 3; i++) begin
      access(1'b1, 1'b0, 32'h0, 32'h0, 1, "sat");
    end
    chk("sat.final", {{(32-CW){1'b0}}, rd_count}, 32'(CMAX));

    // Fill the array so every word has a known value
    for (int i = 0; i < DEPTH; i++) begin
      access(1'b0, 1'b1, 32'(4 * i), $urandom, 1, "fill");
    end

    // Randomized accesses
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 9);
      case ($urandom_range(0, 5))
        0:       ra = 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 100));
        1:       ra = 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
        default: ra = 32'(4 * $urandom_range(0, DEPTH - 1));
      endcase
      rd_v = $urandom;
      if (kind < 5) begin
        access(1'b1, 1'b0, ra, rd_v, $urandom_range(1, 3), "rnd.rd");
      end else if (kind < 9) begin
        access(1'b0, 1'b1, ra, rd_v, $urandom_range(1, 3), "rnd.wr");
      end else begin
        access(1'b1, 1'b1, ra, rd_v, $urandom_range(1, 3), "rnd.both");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
